// File: rtl/writeback_multi.sv
// Multi-lane writeback stage: registers an N-lane retire bundle, resolves link/r0/WAW per lane,
// commits each bundle exactly once and counts retired instructions.
module writeback_multi #(
  parameter int         LANES       = 2,
  parameter int         DATA_W      = 32,
  parameter logic [4:0] LINK_REG    = 5'd31,
  parameter int         LINK_OFFSET = 8,
  parameter int         CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [LANES-1:0]        lane_valid,
  input  logic [LANES*DATA_W-1:0] result,
  input  logic [LANES*DATA_W-1:0] pc_address,
  input  logic [LANES*5-1:0]      reg_dest,
  input  logic [LANES-1:0]        write_en,
  input  logic [LANES-1:0]        branch_link,
  input  logic [LANES-1:0]        link_rd_sel,
  output logic [LANES-1:0]        reg_write_en,
  output logic [LANES*5-1:0]      reg_write_dest,
  output logic [LANES*DATA_W-1:0] reg_write_data,
  output logic [CNT_W-1:0]        retired_count
);

  logic                    valid_q, valid_d;
  logic                    fresh_q, fresh_d;
  logic [LANES-1:0]        lane_valid_q, lane_valid_d;
  logic [LANES*DATA_W-1:0] result_q, result_d;
  logic [LANES*DATA_W-1:0] pc_q, pc_d;
  logic [LANES*5-1:0]      reg_dest_q, reg_dest_d;
  logic [LANES-1:0]        write_en_q, write_en_d;
  logic [LANES-1:0]        branch_link_q, branch_link_d;
  logic [LANES-1:0]        link_rd_sel_q, link_rd_sel_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [4:0]        dest_r [LANES];
  logic [DATA_W-1:0] data_r [LANES];
  logic [LANES-1:0]  req;
  logic [LANES-1:0]  shadowed;
  logic [CNT_W-1:0]  popcnt;

  // fresh_q is only set by a real capture, so a stalled bundle commits once
  always_comb begin
    valid_d       = valid_q;
    fresh_d       = 1'b0;
    lane_valid_d  = lane_valid_q;
    result_d      = result_q;
    pc_d          = pc_q;
    reg_dest_d    = reg_dest_q;
    write_en_d    = write_en_q;
    branch_link_d = branch_link_q;
    link_rd_sel_d = link_rd_sel_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d       = |lane_valid;
      fresh_d       = |lane_valid;
      lane_valid_d  = lane_valid;
      result_d      = result;
      pc_d          = pc_address;
      reg_dest_d    = reg_dest;
      write_en_d    = write_en;
      branch_link_d = branch_link;
      link_rd_sel_d = link_rd_sel;
    end
  end

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < LANES; i++) begin
      popcnt = popcnt + {{(CNT_W-1){1'b0}}, lane_valid_q[i]};
    end
    count_d = fresh_q ? count_q + popcnt : count_q;
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (branch_link_q[i]) begin
        dest_r[i] = link_rd_sel_q[i] ? reg_dest_q[i*5 +: 5] : LINK_REG;
        data_r[i] = pc_q[i*DATA_W +: DATA_W] + DATA_W'(LINK_OFFSET);
      end else begin
        dest_r[i] = reg_dest_q[i*5 +: 5];
        data_r[i] = result_q[i*DATA_W +: DATA_W];
      end
      req[i] = lane_valid_q[i] & (write_en_q[i] | branch_link_q[i]) & (dest_r[i] != 5'd0);
    end
  end

  // A younger lane writing the same register makes the older write redundant
  always_comb begin
    shadowed       = '0;
    reg_write_en   = '0;
    reg_write_dest = '0;
    reg_write_data = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (req[j] && (dest_r[j] == dest_r[i])) begin
          shadowed[i] = 1'b1;
        end
      end
      reg_write_en[i] = fresh_q & req[i] & ~shadowed[i];
      if (valid_q) begin
        reg_write_dest[i*5 +: 5]           = dest_r[i];
        reg_write_data[i*DATA_W +: DATA_W] = data_r[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= 1'b0;
      fresh_q       <= 1'b0;
      lane_valid_q  <= '0;
      result_q      <= '0;
      pc_q          <= '0;
      reg_dest_q    <= '0;
      write_en_q    <= '0;
      branch_link_q <= '0;
      link_rd_sel_q <= '0;
      count_q       <= '0;
    end else begin
      valid_q       <= valid_d;
      fresh_q       <= fresh_d;
      lane_valid_q  <= lane_valid_d;
      result_q      <= result_d;
      pc_q          <= pc_d;
      reg_dest_q    <= reg_dest_d;
      write_en_q    <= write_en_d;
      branch_link_q <= branch_link_d;
      link_rd_sel_q <= link_rd_sel_d;
      count_q       <= count_d;
    end
  end

  assign retired_count = count_q;

endmodule

// File: tb/tb_writeback_multi.sv
// Directed bench for writeback_multi: link resolution, r0/WAW suppression, stall/flush,
// async reset and counter wrap (second instance with a 4-bit counter).
module tb_writeback_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [1:0]  lane_valid, write_en, branch_link, link_rd_sel;
  logic [63:0] result, pc_address;
  logic [9:0]  reg_dest;
  logic [1:0]  en;
  logic [9:0]  dest;
  logic [63:0] data;
  logic [31:0] cnt;
  logic [1:0]  en4;
  logic [9:0]  dest4;
  logic [63:0] data4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_multi #(.LANES(2), .DATA_W(32), .LINK_REG(5'd31), .LINK_OFFSET(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .lane_valid(lane_valid),
    .result(result), .pc_address(pc_address), .reg_dest(reg_dest), .write_en(write_en),
    .branch_link(branch_link), .link_rd_sel(link_rd_sel), .reg_write_en(en),
    .reg_write_dest(dest), .reg_write_data(data), .retired_count(cnt)
  );

  writeback_multi #(.LANES(2), .DATA_W(32), .LINK_REG(5'd31), .LINK_OFFSET(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .lane_valid(lane_valid),
    .result(result), .pc_address(pc_address), .reg_dest(reg_dest), .write_en(write_en),
    .branch_link(branch_link), .link_rd_sel(link_rd_sel), .reg_write_en(en4),
    .reg_write_dest(dest4), .reg_write_data(data4), .retired_count(cnt4)
  );

  task automatic clear_inputs();
    lane_valid  = '0;
    write_en    = '0;
    branch_link = '0;
    link_rd_sel = '0;
    result      = '0;
    pc_address  = '0;
    reg_dest    = '0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic we, input logic bl,
                          input logic sel, input logic [4:0] rd, input logic [31:0] res,
                          input logic [31:0] pc);
    lane_valid[i]          = v;
    write_en[i]            = we;
    branch_link[i]         = bl;
    link_rd_sel[i]         = sel;
    reg_dest[i*5 +: 5]     = rd;
    result[i*32 +: 32]     = res;
    pc_address[i*32 +: 32] = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    clear_inputs();
    #3;
    checks++; if (en !== 2'b00) begin errors++; $display("[TB] FAIL reset_en: got %b expected 00", en); end
    checks++; if (dest !== 10'd0) begin errors++; $display("[TB] FAIL reset_dest: got %h expected 0", dest); end
    checks++; if (data !== 64'd0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", data); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", cnt); end
    #4 rst = 1'b1;
    step();
  endtask

  task automatic test_link();
    set_lane(1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD, 32'h1000);
    step();
    checks++; if (en !== 2'b10) begin errors++; $display("[TB] FAIL link_en: got %b expected 10", en); end
    checks++; if (dest[9:5] !== 5'd31) begin errors++; $display("[TB] FAIL link_dest: got %0d expected 31", dest[9:5]); end
    checks++; if (data[63:32] !== 32'h1008) begin errors++; $display("[TB] FAIL link_data: got %h expected 00001008", data[63:32]); end
    set_lane(1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD, 32'h1000);
    step();
    checks++; if (en !== 2'b10) begin errors++; $display("[TB] FAIL link_rd_en: got %b expected 10", en); end
    checks++; if (dest[9:5] !== 5'd5) begin errors++; $display("[TB] FAIL link_rd_dest: got %0d expected 5", dest[9:5]); end
    checks++; if (data[63:32] !== 32'h1008) begin errors++; $display("[TB] FAIL link_rd_data: got %h expected 00001008", data[63:32]); end
    checks++; if (cnt !== 32'd1) begin errors++; $display("[TB] FAIL link_count1: got %0d expected 1", cnt); end
    clear_inputs();
    step();
    checks++; if (en !== 2'b00) begin errors++; $display("[TB] FAIL link_idle_en: got %b expected 00", en); end
    checks++; if (cnt !== 32'd2) begin errors++; $display("[TB] FAIL link_count2: got %0d expected 2", cnt); end
  endtask

  task automatic test_waw();
    set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h11, 32'h2000);
    set_lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h22, 32'h2004);
    step();
    checks++; if (en !== 2'b10) begin errors++; $display("[TB] FAIL waw_en: got %b expected 10", en); end
    checks++; if (data[63:32] !== 32'h22) begin errors++; $display("[TB] FAIL waw_data1: got %h expected 00000022", data[63:32]); end
    checks++; if (data[31:0] !== 32'h11) begin errors++; $display("[TB] FAIL waw_data0: got %h expected 00000011", data[31:0]); end
    set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h55, 32'h2008);
    set_lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h33, 32'h200C);
    step();
    checks++; if (en !== 2'b10) begin errors++; $display("[TB] FAIL r0_en: got %b expected 10", en); end
    checks++; if (dest[9:5] !== 5'd4) begin errors++; $display("[TB] FAIL r0_dest1: got %0d expected 4", dest[9:5]); end
    checks++; if (cnt !== 32'd4) begin errors++; $display("[TB] FAIL waw_count: got %0d expected 4", cnt); end
    clear_inputs();
    step();
    checks++; if (cnt !== 32'd6) begin errors++; $display("[TB] FAIL r0_count: got %0d expected 6", cnt); end
  endtask

  task automatic test_stall();
    set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h70, 32'h3000);
    set_lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h80, 32'h3004);
    step();
    checks++; if (en !== 2'b11) begin errors++; $display("[TB] FAIL stall_commit_en: got %b expected 11", en); end
    stall = 1'b1;
    set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'hBAD0, 32'h0);
    set_lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd13, 32'hBAD1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (en !== 2'b00) begin errors++; $display("[TB] FAIL stall_en_%0d: got %b expected 00", k, en); end
      checks++; if (cnt !== 32'd8) begin errors++; $display("[TB] FAIL stall_count_%0d: got %0d expected 8", k, cnt); end
      checks++; if (dest !== {5'd8, 5'd7}) begin errors++; $display("[TB] FAIL stall_dest_%0d: got %h expected 107", k, dest); end
      checks++; if (data !== {32'h80, 32'h70}) begin errors++; $display("[TB] FAIL stall_data_%0d: got %h expected 0000008000000070", k, data); end
    end
    stall = 1'b0;
    clear_inputs();
    step();
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1;
    set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 32'h4000);
    step();
    checks++; if (en !== 2'b00) begin errors++; $display("[TB] FAIL flush_stall_en: got %b expected 00", en); end
    checks++; if (dest !== 10'd0) begin errors++; $display("[TB] FAIL flush_stall_dest: got %h expected 0", dest); end
    stall = 1'b0; flush = 1'b0;
    clear_inputs();
    step();
    checks++; if (cnt !== 32'd8) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 8", cnt); end
    set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'hA0, 32'h4010);
    step();
    checks++; if (en !== 2'b01) begin errors++; $display("[TB] FAIL pre_flush_en: got %b expected 01", en); end
    flush = 1'b1;
    set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 32'hB0, 32'h4014);
    set_lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'hC0, 32'h4018);
    step();
    checks++; if (en !== 2'b00) begin errors++; $display("[TB] FAIL flushed_en: got %b expected 00", en); end
    checks++; if (cnt !== 32'd9) begin errors++; $display("[TB] FAIL flush_commit_count: got %0d expected 9", cnt); end
    flush = 1'b0;
    clear_inputs();
    set_lane(0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 32'h0, 32'hFFFFFFFC);
    step();
    checks++; if (en !== 2'b01) begin errors++; $display("[TB] FAIL wrap_link_en: got %b expected 01", en); end
    checks++; if (dest[4:0] !== 5'd31) begin errors++; $display("[TB] FAIL wrap_link_dest: got %0d expected 31", dest[4:0]); end
    checks++; if (data[31:0] !== 32'h4) begin errors++; $display("[TB] FAIL wrap_link_data: got %h expected 00000004", data[31:0]); end
    clear_inputs();
    step();
    checks++; if (cnt !== 32'd10) begin errors++; $display("[TB] FAIL wrap_link_count: got %0d expected 10", cnt); end
  endtask

  task automatic test_reset_mid_commit();
    set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd14, 32'hE0, 32'h5000);
    set_lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd15, 32'hF0, 32'h5004);
    step();
    checks++; if (en !== 2'b11) begin errors++; $display("[TB] FAIL mid_commit_en: got %b expected 11", en); end
    #2 rst = 1'b0;
    #1;
    checks++; if (en !== 2'b00) begin errors++; $display("[TB] FAIL async_rst_en: got %b expected 00", en); end
    checks++; if (dest !== 10'd0) begin errors++; $display("[TB] FAIL async_rst_dest: got %h expected 0", dest); end
    checks++; if (data !== 64'd0) begin errors++; $display("[TB] FAIL async_rst_data: got %h expected 0", data); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("[TB] FAIL async_rst_count: got %0d expected 0", cnt); end
    clear_inputs();
    #3 rst = 1'b1;
    step();
  endtask

  task automatic test_back_to_back_wrap();
    for (int k = 0; k < 7; k++) begin
      set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1 + 5'(k), 32'(k), 32'h6000);
      set_lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd20 + 5'(k), 32'(k + 100), 32'h6004);
      step();
      checks++; if (en !== 2'b11) begin errors++; $display("[TB] FAIL b2b_en_%0d: got %b expected 11", k, en); end
    end
    clear_inputs();
    set_lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h66, 32'h6008);
    step();
    clear_inputs();
    step();
    checks++; if (cnt4 !== 4'd15) begin errors++; $display("[TB] FAIL cnt4_15: got %0d expected 15", cnt4); end
    checks++; if (cnt !== 32'd15) begin errors++; $display("[TB] FAIL cnt_15: got %0d expected 15", cnt); end
    set_lane(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h2, 32'h7000);
    set_lane(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h3, 32'h7004);
    step();
    clear_inputs();
    step();
    checks++; if (cnt4 !== 4'd1) begin errors++; $display("[TB] FAIL cnt4_wrap: got %0d expected 1", cnt4); end
    checks++; if (cnt !== 32'd17) begin errors++; $display("[TB] FAIL cnt_17: got %0d expected 17", cnt); end
  endtask

  initial begin
    test_reset();
    test_link();
    test_waw();
    test_stall();
    test_flush();
    test_reset_mid_commit();
    test_back_to_back_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
